// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: ALU result port, LSU result
// handshake, issue-side scoreboard update and the regfile write port.
interface wb_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
);
    logic               alu_valid_i;
    logic [4:0]         alu_rd_addr_i;
    logic [XLEN-1:0]    alu_rd_data_i;
    logic               alu_stall_o;
    logic               lsu_valid_i;
    logic               lsu_ready_o;
    logic [4:0]         lsu_rd_addr_i;
    logic [XLEN-1:0]    lsu_rd_data_i;
    logic               iss_valid_i;
    logic               iss_long_i;
    logic [4:0]         iss_rd_addr_i;
    logic               rd_we_o;
    logic [4:0]         rd_addr_o;
    logic [XLEN-1:0]    rd_data_o;
    logic [REG_NUM-1:0] busy_o;
    logic [1:0]         fifo_cnt_o;

    // Arbiter side of the bundle.
    modport slave (
        input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        output alu_stall_o,
        input  lsu_valid_i,
        output lsu_ready_o,
        input  lsu_rd_addr_i, lsu_rd_data_i,
        input  iss_valid_i, iss_long_i, iss_rd_addr_i,
        output rd_we_o, rd_addr_o, rd_data_o, busy_o, fifo_cnt_o
    );

    // Producer / consumer side of the bundle.
    modport master (
        output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        input  alu_stall_o,
        output lsu_valid_i,
        input  lsu_ready_o,
        output lsu_rd_addr_i, lsu_rd_data_i,
        output iss_valid_i, iss_long_i, iss_rd_addr_i,
        input  rd_we_o, rd_addr_o, rd_data_o, busy_o, fifo_cnt_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with long-latency LSU
// results buffered in a 2-entry FIFO, with an anti-starvation counter that
// eventually forces the LSU path, and a busy scoreboard for pending loads.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_NUM    = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.slave  bus
);
    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] { SEL_NONE, SEL_ALU, SEL_LSU } sel_e;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t               mem_q [2];
    entry_t               mem_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 rd_we_q, rd_we_d;
    logic [4:0]           rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]      rd_data_q, rd_data_d;
    logic [REG_NUM-1:0]   busy_q, busy_d;

    sel_e                 sel;
    entry_t               head;
    logic                 fifo_empty;
    logic                 forced;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic [REG_NUM-1:0]   set_mask;
    logic [REG_NUM-1:0]   clr_mask;

    // Source selection, FIFO bookkeeping, starvation counter, result register and scoreboard next-state.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        fifo_empty = (cnt_q == 2'd0);
        forced     = (starve_q == STARVE_W'(STARVE_MAX)) && !fifo_empty;
        ready      = !rst_i && (cnt_q != 2'd2);
        push       = bus.lsu_valid_i && ready;

        sel = SEL_NONE;
        if (forced) begin
            sel = SEL_LSU;
        end else if (bus.alu_valid_i) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_LSU;
        end
        pop = (sel == SEL_LSU);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: bus.lsu_rd_addr_i, data: bus.lsu_rd_data_i};
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (sel == SEL_ALU && starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        clr_mask  = '0;
        case (sel)
            SEL_ALU: begin
                rd_we_d   = (bus.alu_rd_addr_i != 5'd0);
                rd_addr_d = bus.alu_rd_addr_i;
                rd_data_d = bus.alu_rd_data_i;
            end
            SEL_LSU: begin
                rd_we_d   = (head.addr != 5'd0);
                rd_addr_d = head.addr;
                rd_data_d = head.data;
                if (head.addr != 5'd0 && int'(head.addr) < REG_NUM) begin
                    clr_mask[head.addr] = 1'b1;
                end
            end
            default: ;
        endcase

        set_mask = '0;
        if (bus.iss_valid_i && bus.iss_long_i && bus.iss_rd_addr_i != 5'd0
            && int'(bus.iss_rd_addr_i) < REG_NUM) begin
            set_mask[bus.iss_rd_addr_i] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // State register with synchronous reset that drops FIFO contents and pending busy bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            starve_q  <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.alu_stall_o = forced && bus.alu_valid_i;
    assign bus.lsu_ready_o = ready;
    assign bus.rd_we_o     = rd_we_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.busy_o      = busy_q;
    assign bus.fifo_cnt_o  = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_wb_arbiter;
    localparam int XLEN       = 32;
    localparam int REG_NUM    = 32;
    localparam int STARVE_MAX = 3;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } result_t;

    logic clk;
    logic rst;

    wb_arbiter_if #(.XLEN(XLEN), .REG_NUM(REG_NUM)) bus ();

    wb_arbiter #(.XLEN(XLEN), .REG_NUM(REG_NUM), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          passCount  = 0;
    int          checkCount = 0;

    result_t     pending[$];
    int          starveAge;
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic [31:0] expBusy;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model predicts for the current cycle.
    task automatic checkOutput();
        int  depth;
        bit  forcedNow;
        depth     = pending.size();
        forcedNow = (starveAge == STARVE_MAX) && (depth > 0);
        checkValue("rd_we",     64'(bus.rd_we_o),     64'(expWe));
        checkValue("rd_addr",   64'(bus.rd_addr_o),   64'(expAddr));
        checkValue("rd_data",   64'(bus.rd_data_o),   64'(expData));
        checkValue("busy",      64'(bus.busy_o),      64'(expBusy));
        checkValue("fifo_cnt",  64'(bus.fifo_cnt_o),  64'(depth));
        checkValue("lsu_ready", 64'(bus.lsu_ready_o), 64'(!rst && depth < 2));
        checkValue("alu_stall", 64'(bus.alu_stall_o), 64'(forcedNow && bus.alu_valid_i));
    endtask

    // Advance the model across the coming clock edge using the inputs currently driven.
    task automatic modelStep();
        int      depth;
        bit      forcedNow;
        bit      takeLsu;
        bit      takeAlu;
        bit      accepted;
        result_t r;
        if (rst) begin
            pending.delete();
            starveAge = 0;
            expWe     = 1'b0;
            expAddr   = 5'd0;
            expData   = 32'd0;
            expBusy   = 32'd0;
            return;
        end
        depth     = pending.size();
        forcedNow = (starveAge == STARVE_MAX) && (depth > 0);
        takeLsu   = forcedNow || (!bus.alu_valid_i && depth > 0);
        takeAlu   = !forcedNow && bus.alu_valid_i;
        accepted  = bus.lsu_valid_i && depth < 2;
        if (takeLsu) begin
            r       = pending.pop_front();
            expWe   = (r.addr != 0);
            expAddr = r.addr;
            expData = r.data;
            if (r.addr != 0) expBusy[r.addr] = 1'b0;
        end else if (takeAlu) begin
            expWe   = (bus.alu_rd_addr_i != 0);
            expAddr = bus.alu_rd_addr_i;
            expData = bus.alu_rd_data_i;
        end else begin
            expWe = 1'b0;
        end
        if (depth == 0 || takeLsu) starveAge = 0;
        else starveAge = (starveAge + 1 > STARVE_MAX) ? STARVE_MAX : starveAge + 1;
        if (bus.iss_valid_i && bus.iss_long_i && bus.iss_rd_addr_i != 0)
            expBusy[bus.iss_rd_addr_i] = 1'b1;
        if (accepted) begin
            r.addr = bus.lsu_rd_addr_i;
            r.data = bus.lsu_rd_data_i;
            pending.push_back(r);
        end
    endtask

    // Drive one cycle of inputs, check outputs, then step the model over the edge.
    task automatic applyStimulus(input bit r,
                                 input bit aV, input logic [4:0] aA, input logic [31:0] aD,
                                 input bit lV, input logic [4:0] lA, input logic [31:0] lD,
                                 input bit iV, input bit iL, input logic [4:0] iA);
        @(negedge clk);
        rst               = r;
        bus.alu_valid_i   = aV;
        bus.alu_rd_addr_i = aA;
        bus.alu_rd_data_i = aD;
        bus.lsu_valid_i   = lV;
        bus.lsu_rd_addr_i = lA;
        bus.lsu_rd_data_i = lD;
        bus.iss_valid_i   = iV;
        bus.iss_long_i    = iL;
        bus.iss_rd_addr_i = iA;
        #1;
        checkOutput();
        modelStep();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        rst               = 1'b1;
        bus.alu_valid_i   = 1'b0;
        bus.alu_rd_addr_i = 5'd0;
        bus.alu_rd_data_i = 32'd0;
        bus.lsu_valid_i   = 1'b0;
        bus.lsu_rd_addr_i = 5'd0;
        bus.lsu_rd_data_i = 32'd0;
        bus.iss_valid_i   = 1'b0;
        bus.iss_long_i    = 1'b0;
        bus.iss_rd_addr_i = 5'd0;
        pending.delete();
        starveAge = 0;
        expWe     = 1'b0;
        expAddr   = 5'd0;
        expData   = 32'd0;
        expBusy   = 32'd0;
        @(posedge clk);

        $display("[TB] reset");
        applyStimulus(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0);

        $display("[TB] ALU only");
        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 0, 5'd0);
        idle();

        $display("[TB] long op to x7");
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, 5'd7);
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234, 0, 0, 5'd0);
        idle();
        idle();
        idle();

        $display("[TB] backpressure");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 5'(10 + i), 32'hA000 + i, (i < 3), 5'(20 + i), 32'hB000 + i, 0, 0, 5'd0);
        for (int i = 0; i < 4; i++) idle();

        $display("[TB] x0 writes");
        applyStimulus(0, 1, 5'd0, 32'h11111111, 0, 5'd0, 32'd0, 0, 0, 5'd0);
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h22222222, 1, 1, 5'd0);
        idle();
        idle();

        $display("[TB] set/clear collision on x9");
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, 5'd9);
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0, 0, 5'd0);
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, 5'd9);
        idle();
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h9A, 0, 0, 5'd0);
        idle();
        idle();

        $display("[TB] reset mid-operation");
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, 5'd7);
        applyStimulus(0, 1, 5'd1, 32'h1, 1, 5'd7, 32'h70, 0, 0, 5'd0);
        applyStimulus(0, 1, 5'd2, 32'h2, 1, 5'd7, 32'h71, 0, 0, 5'd0);
        applyStimulus(1, 1, 5'd3, 32'h3, 1, 5'd8, 32'h80, 1, 1, 5'd4);
        idle();
        idle();

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++)
            applyStimulus(($urandom_range(0, 63) == 0),
                          1'($urandom), 5'($urandom_range(0, 15)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 15)), $urandom,
                          1'($urandom), 1'($urandom), 5'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; REG_NUM, default 32, architectural register count; STARVE_MAX, default 3, ALU-priority cycles allowed before the load path is forced.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  single-cycle ALU result present.
- alu_rd_addr_i  in  5  ALU destination register.
- alu_rd_data_i  in  XLEN  ALU result.
- alu_stall_o  out  1  ALU result not consumed this cycle; upstream holds it.
- lsu_valid_i  in  1  long-latency (load/mul) result offered.
- lsu_ready_o  out  1  FIFO can accept an LSU result.
- lsu_rd_addr_i  in  5  LSU destination register.
- lsu_rd_data_i  in  XLEN  LSU result.
- iss_valid_i  in  1  instruction issued this cycle.
- iss_long_i  in  1  issued instruction completes via the LSU path.
- iss_rd_addr_i  in  5  issued instruction's destination register.
- rd_we_o  out  1  regfile write enable.
- rd_addr_o  out  5  regfile write address.
- rd_data_o  out  XLEN  regfile write data.
- busy_o  out  REG_NUM  scoreboard; bit n = register n has a pending long-latency write.
- fifo_cnt_o  out  2  LSU FIFO occupancy, 0..2.

Function
REQ-003 The LSU handshake SHALL complete (push) on a cycle where lsu_valid_i and lsu_ready_o are both 1; lsu_ready_o = !rst_i and fifo_cnt_o < 2.
REQ-004 The LSU FIFO SHALL hold 2 entries with in-order pop; a push and a pop in the same cycle SHALL leave the count unchanged; a pushed entry becomes eligible the following cycle.
REQ-005 Selection per cycle: if starve_cnt == STARVE_MAX and the FIFO is non-empty, the SHALL select the FIFO head and assert alu_stall_o = alu_valid_i; otherwise, if alu_valid_i, the block SHALL select ALU with alu_stall_o = 0; otherwise, if the FIFO is non-empty, it SHALL select the FIFO head; otherwise nothing is selected.
REQ-006 alu_stall_o SHALL be combinational and asserted only in the forced case of REQ-005.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_MAX) in each cycle where the FIFO is non-empty and the ALU is selected, and SHALL clear whenever the FIFO head is popped or the FIFO is empty.
REQ-008 The selected result SHALL be registered: rd_we_o, rd_addr_o and rd_data_o update one cycle after selection. ALU latency is 1 cycle; LSU latency is at least 2 cycles from push.
REQ-009 A selected result with rd_addr 0 SHALL be consumed (popped or accepted) and produce rd_we_o = 0; rd_addr_o and rd_data_o still update.
REQ-010 When nothing is selected, rd_we_o SHALL be 0 and rd_addr_o and rd_data_o SHALL hold their previous values.
REQ-011 A busy bit SHALL be set on the edge after iss_valid_i & iss_long_i with iss_rd_addr_i != 0; busy_o[0] SHALL be constantly 0.
REQ-012 A busy bit SHALL clear on the same edge at which an LSU-path write to that register is registered into rd_*_o.
REQ-013 If set and clear of the same busy bit coincide, set SHALL win.
REQ-014 ALU writes SHALL never alter busy_o.

Reset
REQ-015 While rst_i = 1 at a rising edge, the block SHALL set: rd_we_o = 0, rd_addr_o = 0, rd_data_o = 0, busy_o = 0, FIFO empty (fifo_cnt_o = 0), starve_cnt = 0; lsu_ready_o SHALL be 0 during reset.
REQ-016 Reset asserted mid-operation SHALL discard FIFO contents and pending busy bits with no write emitted; the first post-reset cycle SHALL have lsu_ready_o = 1.

Verification
REQ-017 ALU only: alu_valid_i=1, addr 5, data 0xDEADBEEF at cycle t -> rd_we_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF at t+1; alu_stall_o=0.
REQ-018 Long op: issue long to x7 -> busy_o[7]=1; LSU push (x7, 0x1234) at t -> write at t+2 and busy_o[7]=0 after that edge.
REQ-019 Backpressure: 3 LSU pushes with alu_valid_i held 1 -> fifo_cnt_o reaches 2 and lsu_ready_o=0; on the 4th ALU-priority cycle alu_stall_o=1 and the FIFO head is written; the held ALU result is written next.
REQ-020 x0: ALU write to x0, then LSU write to x0 -> rd_we_o=0 both times, FIFO drains to 0, busy_o[0]=0.
REQ-021 Collision: re-issue long to x9 in the same cycle x9's prior LSU write retires -> busy_o[9] stays 1.
REQ-022 Reset mid-op: with FIFO=2 and busy_o=0x80, assert rst_i for 1 cycle -> all outputs 0 with no write; the next cycle lsu_ready_o=1.
